// File: rtl/divider_pkg.sv
// Shared width, constants and operand type for the signed divider.
package divider_pkg;
  localparam int DATA_W = 16;
  localparam logic signed [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  typedef logic signed [DATA_W-1:0] data_t;
endpackage

// File: rtl/divider_stage.sv
// One restoring-division step: shift in a dividend bit, subtract if it fits.
module divider_stage
  import divider_pkg::*;
#(
  parameter int M = DATA_W + 1
) (
  input  logic [M-1:0] rem_in,
  input  logic         bit_in,
  input  logic [M-1:0] div_mag,
  output logic [M-1:0] rem_out,
  output logic         q_bit
);
  logic [M:0] shifted;
  logic [M:0] trial;

  always_comb begin
    shifted = {rem_in, bit_in};
    trial   = shifted - {1'b0, div_mag};
    // Borrow out of the top bit means the divisor did not fit.
    q_bit   = ~trial[M];
    rem_out = q_bit ? trial[M-1:0] : shifted[M-1:0];
  end
endmodule

// File: rtl/divider.sv
// Signed divider: magnitude restoring array, sign fix-up, registered outputs.
module divider
  import divider_pkg::*;
#(
  parameter int DATA_W = divider_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] Dividend,
  input  logic signed [DATA_W-1:0] Divisor,
  output logic signed [DATA_W-1:0] Quotient,
  output logic signed [DATA_W-1:0] Remain,
  output logic                     error
);
  localparam int M = DATA_W + 1;
  localparam logic [DATA_W-1:0] MIN_NEG_W = {1'b1, {(DATA_W-1){1'b0}}};

  logic [M-1:0]      a_ext, b_ext, a_mag, b_mag;
  logic [M-1:0]      rem_chain [DATA_W+1];
  logic [DATA_W-1:0] q_mag, r_lo;
  logic [DATA_W-1:0] q_next, r_next;
  logic              e_next, div_zero, overflow;

  always_comb begin
    a_ext = {Dividend[DATA_W-1], Dividend};
    b_ext = {Divisor[DATA_W-1], Divisor};
    a_mag = a_ext[M-1] ? -a_ext : a_ext;
    b_mag = b_ext[M-1] ? -b_ext : b_ext;
  end

  // The magnitude's top bit seeds the partial remainder so every bit is consumed.
  assign rem_chain[0] = {{DATA_W{1'b0}}, a_mag[DATA_W]};

  for (genvar i = 0; i < DATA_W; i++) begin : g_stage
    divider_stage #(.M(M)) u_stage (
      .rem_in  (rem_chain[i]),
      .bit_in  (a_mag[DATA_W-1-i]),
      .div_mag (b_mag),
      .rem_out (rem_chain[i+1]),
      .q_bit   (q_mag[DATA_W-1-i])
    );
  end

  always_comb begin
    div_zero = (Divisor == '0);
    overflow = (Dividend == MIN_NEG_W) && (Divisor == '1);
    r_lo     = rem_chain[DATA_W][DATA_W-1:0];
    q_next   = (Dividend[DATA_W-1] ^ Divisor[DATA_W-1]) ? -q_mag : q_mag;
    r_next   = Dividend[DATA_W-1] ? -r_lo : r_lo;
    e_next   = div_zero | overflow;
    // Overflow needs no override: the wrapped magnitude already reads as MIN_NEG.
    if (div_zero) begin
      q_next = '0;
      r_next = Dividend;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Quotient <= '0;
      Remain   <= '0;
      error    <= 1'b0;
    end else begin
      Quotient <= q_next;
      Remain   <= r_next;
      error    <= e_next;
    end
  end
endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: stimulus pushes expectations, monitor pops and compares.
module tb_divider;
  import divider_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  data_t Dividend, Divisor, Quotient, Remain;
  logic  error;

  int tests = 0;
  int fails = 0;

  typedef struct {
    data_t q;
    data_t r;
    logic  e;
    int    idx;
  } exp_t;

  typedef struct {
    data_t a;
    data_t b;
    data_t q;
    data_t r;
    logic  e;
  } vec_t;

  exp_t sb[$];
  int   vec_idx = 0;

  divider #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Dividend (Dividend),
    .Divisor  (Divisor),
    .Quotient (Quotient),
    .Remain   (Remain),
    .error    (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx,
                       input logic signed [31:0] act, input logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  function automatic void ref_model(input data_t a, input data_t b,
                                    output data_t q, output data_t r, output logic e);
    if (b == 0) begin
      q = 0; r = a; e = 1'b1;
    end else if (a == MIN_NEG && b == -1) begin
      q = MIN_NEG; r = 0; e = 1'b1;
    end else begin
      q = a / b; r = a % b; e = 1'b0;
    end
  endfunction

  task automatic push_exp(input data_t q, input data_t r, input logic e);
    exp_t x;
    x.q = q; x.r = r; x.e = e; x.idx = vec_idx;
    vec_idx++;
    sb.push_back(x);
  endtask

  task automatic apply_hand(input vec_t v);
    @(negedge clk);
    Dividend = v.a;
    Divisor  = v.b;
    push_exp(v.q, v.r, v.e);
  endtask

  task automatic apply_model(input data_t a, input data_t b);
    data_t q, r;
    logic  e;
    @(negedge clk);
    Dividend = a;
    Divisor  = b;
    ref_model(a, b, q, r, e);
    push_exp(q, r, e);
  endtask

  // Monitor: outputs are valid for the whole cycle after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_t x;
        x = sb.pop_front();
        check("quotient", x.idx, Quotient, x.q);
        check("remain",   x.idx, Remain,   x.r);
        check("error",    x.idx, error,    x.e);
      end
    end
  end

  vec_t dir [11] = '{
    '{a:  100,    b:  7,     q:  14,     r:  2,    e: 1'b0},
    '{a: -100,    b:  7,     q: -14,     r: -2,    e: 1'b0},
    '{a:  100,    b: -7,     q: -14,     r:  2,    e: 1'b0},
    '{a: -100,    b: -7,     q:  14,     r: -2,    e: 1'b0},
    '{a:  32767,  b:  1,     q:  32767,  r:  0,    e: 1'b0},
    '{a: -32768,  b:  2,     q: -16384,  r:  0,    e: 1'b0},
    '{a: -32768,  b:  32767, q: -1,      r: -1,    e: 1'b0},
    '{a:  5,      b:  9,     q:  0,      r:  5,    e: 1'b0},
    '{a:  1234,   b:  0,     q:  0,      r:  1234, e: 1'b1},
    '{a: -32768,  b: -1,     q: -32768,  r:  0,    e: 1'b1},
    '{a:  7,      b:  2,     q:  3,      r:  1,    e: 1'b0}
  };

  data_t stream_a [10] = '{ 17, -17, 300, -301, 0, 1, -1, 12345, -32768, 999 };
  data_t stream_b [10] = '{ 5,  5,  -13,  -13, 3, -1, 3,  -123,   -2,    1000 };

  initial begin
    rst_n    = 1'b0;
    Dividend = 100;
    Divisor  = 7;
    repeat (2) @(posedge clk);
    #1;
    check("rst_quotient", 0, Quotient, 0);
    check("rst_remain",   0, Remain,   0);
    check("rst_error",    0, error,    0);

    @(negedge clk);
    rst_n = 1'b1;
    push_exp(14, 2, 1'b0);

    for (int i = 0; i < 11; i++) apply_hand(dir[i]);
    for (int i = 0; i < 10; i++) apply_model(stream_a[i], stream_b[i]);

    // Reset mid-stream: the pending 1/1 result must never appear.
    @(negedge clk);
    Dividend = 1;
    Divisor  = 1;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_quotient", 0, Quotient, 0);
    check("midrst_remain",   0, Remain,   0);
    check("midrst_error",    0, error,    0);
    @(negedge clk);
    rst_n = 1'b1;
    Dividend = -100;
    Divisor  = -7;
    push_exp(14, -2, 1'b0);

    for (int i = 0; i < 10000; i++) begin
      int unsigned sel;
      data_t a, b;
      sel = $urandom_range(0, 99);
      a = data_t'($urandom);
      b = data_t'($urandom);
      if (sel < 3) b = 0;
      else if (sel == 3) begin a = MIN_NEG; b = -1; end
      else if (sel < 8) b = data_t'($urandom_range(0, 6)) - data_t'(3);
      apply_model(a, b);
    end

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 0, sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
